if_fetch_unit: RTL and testbench

Instruction fetch stage for the RV64IM core. It owns the program counter and drives the instruction ROM index. It captures each returned 32-bit instruction together with its PC into a small FIFO and presents them to decode over a valid/ready handshake. Control-flow redirects from execute flush in-flight fetches and restart fetch at the target address.

---
 rtl/if_fetch_unit.sv | 77 +++++++
 tb/tb_if_fetch_unit.sv | 129 ++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, indexes the instruction ROM and buffers
// {pc, instr} pairs in a small FIFO toward decode. Execute redirects flush it.
module if_fetch_unit #(
  parameter int                PC_LEN     = 64,
  parameter int                INSTR_LEN  = 32,
  parameter logic [PC_LEN-1:0] RST_PC     = 64'h0000_0000_8000_0000,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [PC_LEN-1:0]    rom_idx_o,
  input  logic [INSTR_LEN-1:0] rom_data_i,
  input  logic                 redirect_valid_i,
  input  logic [PC_LEN-1:0]    redirect_pc_i,
  output logic                 if_valid_o,
  input  logic                 if_ready_i,
  output logic [PC_LEN-1:0]    if_pc_o,
  output logic [INSTR_LEN-1:0] if_instr_o,
  output logic [31:0]          fetch_cnt_o
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [PC_LEN-1:0]    pc;
    logic [INSTR_LEN-1:0] instr;
  } fetch_entry_t;

  fetch_entry_t         fifo_q [FIFO_DEPTH];
  logic [PC_LEN-1:0]    pc_q;
  logic [PTR_W-1:0]     head_q, tail_q;
  logic [CNT_W-1:0]     count_q;
  logic [31:0]          fetch_cnt_q;
  logic                 deq, push;

  assign if_valid_o  = (count_q != '0);
  assign deq         = if_valid_o && if_ready_i && !redirect_valid_i;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push        = !redirect_valid_i && ((count_q < CNT_W'(FIFO_DEPTH)) || deq);
  assign rom_idx_o   = pc_q;
  assign if_pc_o     = fifo_q[head_q].pc;
  assign if_instr_o  = fifo_q[head_q].instr;
  assign fetch_cnt_o = fetch_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RST_PC;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      fetch_cnt_q <= '0;
    end else if (redirect_valid_i) begin
      pc_q    <= {redirect_pc_i[PC_LEN-1:2], 2'b00};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        pc_q        <= pc_q + PC_LEN'(4);
        tail_q      <= tail_q + PTR_W'(1);
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (deq)
        head_q <= head_q + PTR_W'(1);
      if (push && !deq)
        count_q <= count_q + CNT_W'(1);
      else if (deq && !push)
        count_q <= count_q - CNT_W'(1);
    end
  end

  // Storage carries no reset; entries are only meaningful behind count_q.
  always_ff @(posedge clk) begin
    if (push && !rst)
      fifo_q[tail_q] <= '{pc: pc_q, instr: rom_data_i};
  end
endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: stream, backpressure, full-FIFO handshakes,
// redirect flush, reset mid-stream and PC wrap on a second instance.
module tb_if_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        if_ready;

  logic [63:0] rom_idx, if_pc, w_rom_idx, w_if_pc;
  logic [31:0] rom_data, if_instr, fetch_cnt, w_rom_data, w_if_instr, w_fetch_cnt;
  logic        if_valid, w_if_valid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_f(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  assign rom_data   = rom_f(rom_idx);
  assign w_rom_data = rom_f(w_rom_idx);

  if_fetch_unit dut (
    .clk(clk), .rst(rst), .rom_idx_o(rom_idx), .rom_data_i(rom_data),
    .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
    .if_valid_o(if_valid), .if_ready_i(if_ready), .if_pc_o(if_pc),
    .if_instr_o(if_instr), .fetch_cnt_o(fetch_cnt)
  );

  if_fetch_unit #(.RST_PC(64'hFFFF_FFFF_FFFF_FFF8)) dut_w (
    .clk(clk), .rst(rst), .rom_idx_o(w_rom_idx), .rom_data_i(w_rom_data),
    .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
    .if_valid_o(w_if_valid), .if_ready_i(if_ready), .if_pc_o(w_if_pc),
    .if_instr_o(w_if_instr), .fetch_cnt_o(w_fetch_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b1;
    cyc(); cyc();
  endtask

  initial begin
    do_reset();
    chk("rst_rom_idx",   rom_idx,   64'h8000_0000);
    chk("rst_valid",     if_valid,  0);
    chk("rst_fetch_cnt", fetch_cnt, 0);

    // Stream with decode always ready; wrap instance runs alongside.
    rst = 1'b0;
    chk("R_valid", if_valid, 0);
    cyc();
    for (int k = 0; k < 10; k++) begin
      chk("str_valid", if_valid, 1);
      chk("str_pc", if_pc, 64'h8000_0000 + 64'(4 * k));
      chk("str_instr", if_instr, rom_f(64'h8000_0000 + 64'(4 * k)));
      chk("str_cnt", fetch_cnt, 32'(k + 1));
      if (k < 4) chk("wrap_pc", w_if_pc, 64'hFFFF_FFFF_FFFF_FFF8 + 64'(4 * k));
      cyc();
    end

    // Backpressure from reset release: ready low for cycles R..R+5.
    do_reset();
    rst = 1'b0; if_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k >= 2) begin
        chk("bp_rom_idx", rom_idx, 64'h8000_0008);
        chk("bp_pc", if_pc, 64'h8000_0000);
        chk("bp_instr", if_instr, rom_f(64'h8000_0000));
      end
      cyc();
    end
    // Ready pattern 1,1,0,1 with FIFO full: head and ROM index per cycle.
    if_ready = 1'b1;
    chk("pp0_pc", if_pc, 64'h8000_0000); chk("pp0_idx", rom_idx, 64'h8000_0008);
    cyc();
    chk("pp1_pc", if_pc, 64'h8000_0004); chk("pp1_idx", rom_idx, 64'h8000_000C);
    cyc();
    if_ready = 1'b0;
    chk("pp2_pc", if_pc, 64'h8000_0008); chk("pp2_idx", rom_idx, 64'h8000_0010);
    cyc();
    if_ready = 1'b1;
    chk("pp3_pc", if_pc, 64'h8000_0008); chk("pp3_idx", rom_idx, 64'h8000_0010);
    cyc();
    if_ready = 1'b0;
    chk("pp4_pc", if_pc, 64'h8000_000C); chk("pp4_valid", if_valid, 1);
    cyc();

    // Redirect while full, decode ready: head 0x8000000C must be dropped.
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0103; if_ready = 1'b1;
    chk("rd_head_before", if_pc, 64'h8000_000C);
    cyc();
    redirect_valid = 1'b0;
    chk("rd_valid", if_valid, 0);
    chk("rd_rom_idx", rom_idx, 64'h8000_0100);
    chk("rd_fetch_cnt", fetch_cnt, 5);
    cyc();
    chk("rd_pc", if_pc, 64'h8000_0100);
    chk("rd_valid2", if_valid, 1);
    chk("rd_fetch_cnt2", fetch_cnt, 6);
    cyc();
    chk("rd_pc_next", if_pc, 64'h8000_0104);

    // Reset together with a redirect: reset wins.
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h1234_5678;
    cyc();
    chk("mr_rom_idx", rom_idx, 64'h8000_0000);
    chk("mr_valid", if_valid, 0);
    chk("mr_fetch_cnt", fetch_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
